cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_cp0_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_ctrl -- MIPS-style coprocessor-0 control block.
//
// Holds the BadVAddr, Count, Compare, Status, Cause, EPC and PRId registers.
// Handles software mtc0 writes, exception entry and eret, the prescaled Count
// timer with its sticky Compare interrupt, and the interrupt request to the
// pipeline.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   we_i/waddr_i/wdata_i  software register write (mtc0)
//   raddr_i/rdata_o    combinational register read (mfc0); no write bypass
//   int_i              external hardware interrupt levels (INT_W lines)
//   exc_*_i            exception commit pulse and its PC / BD / code / address
//   eret_i             eret commit pulse
//   *_o (32-bit)       architectural register contents
//   timer_int_o        sticky timer interrupt
//   int_req_o          enabled, unmasked interrupt request
// -----------------------------------------------------------------------------
module cp0_ctrl #(
    parameter int          INT_W    = 6,
    parameter int          CNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL = 32'h00004220
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [4:0]       waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [4:0]       raddr_i,
    output logic [31:0]      rdata_o,
    input  logic [INT_W-1:0] int_i,
    input  logic             exc_valid_i,
    input  logic [4:0]       exc_code_i,
    input  logic [31:0]      exc_pc_i,
    input  logic             exc_bd_i,
    input  logic [31:0]      exc_badva_i,
    input  logic             eret_i,
    output logic [31:0]      badvaddr_o,
    output logic [31:0]      count_o,
    output logic [31:0]      compare_o,
    output logic [31:0]      status_o,
    output logic [31:0]      cause_o,
    output logic [31:0]      epc_o,
    output logic             timer_int_o,
    output logic             int_req_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Prescaler value on which Count advances.
    localparam logic [1:0] PRESC_LAST = 2'(CNT_DIV - 1);

    // Architectural state
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [1:0]  presc_q;
    logic        timer_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_hw_q;       // sampled int_i, Cause[15:10] before timer OR
    logic [1:0]  ip_sw_q;       // Cause[9:8]
    logic [4:0]  exc_code_q;    // Cause[6:2]

    // Hardware lines zero-extended to the six IP2..IP7 slots.
    logic [5:0] int_ext;
    assign int_ext = 6'(int_i);

    // Software write decode
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    assign wr_count   = we_i && (waddr_i == REG_COUNT);
    assign wr_compare = we_i && (waddr_i == REG_COMPARE);
    assign wr_status  = we_i && (waddr_i == REG_STATUS);
    assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
    assign wr_epc     = we_i && (waddr_i == REG_EPC);

    logic timer_match;
    assign timer_match = (compare_q != 32'd0) && (count_q == compare_q);

    logic addr_exc;
    assign addr_exc = (exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            presc_q    <= 2'd0;
            timer_q    <= 1'b0;
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_hw_q    <= 6'd0;
            ip_sw_q    <= 2'd0;
            exc_code_q <= 5'd0;
        end else begin
            // Count: a software load replaces the increment and restarts the
            // prescaler so the loaded value is held for a full CNT_DIV period.
            if (wr_count) begin
                count_q <= wdata_i;
                presc_q <= 2'd0;
            end else if (presc_q == PRESC_LAST) begin
                count_q <= count_q + 32'd1;
                presc_q <= 2'd0;
            end else begin
                presc_q <= presc_q + 2'd1;
            end

            // Compare write acknowledges the timer, even against a live match.
            if (wr_compare) begin
                compare_q <= wdata_i;
                timer_q   <= 1'b0;
            end else if (timer_match) begin
                timer_q   <= 1'b1;
            end

            ip_hw_q <= int_ext;

            if (wr_status) begin
                im_q <= wdata_i[15:8];
                ie_q <= wdata_i[0];
            end

            if (wr_cause) begin
                ip_sw_q <= wdata_i[9:8];
            end

            // EXL is the one field all three sources contend for.
            if (exc_valid_i) begin
                exl_q <= 1'b1;
            end else if (eret_i) begin
                exl_q <= 1'b0;
            end else if (wr_status) begin
                exl_q <= wdata_i[1];
            end

            // An exception cycle owns EPC; a nested exception leaves the
            // outer return address and BD flag intact.
            if (exc_valid_i) begin
                exc_code_q <= exc_code_i;
                if (!exl_q) begin
                    epc_q <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                    bd_q  <= exc_bd_i;
                end
                if (addr_exc) begin
                    badvaddr_q <= exc_badva_i;
                end
            end else if (wr_epc) begin
                epc_q <= wdata_i;
            end
        end
    end

    // Register views
    assign badvaddr_o  = badvaddr_q;
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_q;
    assign status_o    = {3'b000, 1'b1, 12'h000, im_q, 6'b000000, exl_q, ie_q};
    // IP7 combines hardware line 5 (zero when absent) with the timer.
    assign cause_o     = {bd_q, 15'h0000, ip_hw_q[5] | timer_q, ip_hw_q[4:0],
                          ip_sw_q, 1'b0, exc_code_q, 2'b00};

    assign int_req_o = ie_q & ~exl_q & (|(cause_o[15:8] & im_q));

    // NOTE: the default assignment first keeps this block free of latches for
    // every unmapped register number.
    always_comb begin
        rdata_o = 32'd0;
        if (!rst) begin
            unique case (raddr_i)
                REG_BADVADDR: rdata_o = badvaddr_q;
                REG_COUNT:    rdata_o = count_q;
                REG_COMPARE:  rdata_o = compare_q;
                REG_STATUS:   rdata_o = status_o;
                REG_CAUSE:    rdata_o = cause_o;
                REG_EPC:      rdata_o = epc_q;
                REG_PRID:     rdata_o = PRID_VAL;
                default:      rdata_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_ctrl -- directed self-checking bench for cp0_ctrl (CNT_DIV = 2).
// Inputs change just after the falling edge; outputs are checked at the
// falling edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic [31:0] exc_badva_i;
    logic        eret_i;
    logic [31:0] badvaddr_o, count_o, compare_o, status_o, cause_o, epc_o;
    logic        timer_int_o;
    logic        int_req_o;

    int n_checks = 0;
    int n_errors = 0;

    cp0_ctrl #(.INT_W(6), .CNT_DIV(2), .PRID_VAL(32'h00004220)) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .raddr_i     (raddr_i),
        .rdata_o     (rdata_o),
        .int_i       (int_i),
        .exc_valid_i (exc_valid_i),
        .exc_code_i  (exc_code_i),
        .exc_pc_i    (exc_pc_i),
        .exc_bd_i    (exc_bd_i),
        .exc_badva_i (exc_badva_i),
        .eret_i      (eret_i),
        .badvaddr_o  (badvaddr_o),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .timer_int_o (timer_int_o),
        .int_req_o   (int_req_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: through the rising edge, stop at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sw_write(input logic [4:0] addr, input logic [31:0] data);
        we_i    = 1'b1;
        waddr_i = addr;
        wdata_i = data;
        tick();
        we_i    = 1'b0;
    endtask

    task automatic set_exc(input logic [31:0] pc, input logic bd,
                           input logic [4:0] code, input logic [31:0] badva);
        exc_valid_i = 1'b1;
        exc_pc_i    = pc;
        exc_bd_i    = bd;
        exc_code_i  = code;
        exc_badva_i = badva;
    endtask

    task automatic pulse_eret();
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
    endtask

    // Bounded wait for count_o to reach a value; a timeout counts as a failure.
    task automatic wait_count(input logic [31:0] target, input string tag);
        int budget = 200;
        while (count_o !== target && budget > 0) begin
            tick();
            budget--;
        end
        check(tag, count_o, target);
    endtask

    logic [31:0] target;

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = 5'd12;
        int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0;
        exc_bd_i = 1'b0; exc_badva_i = '0; eret_i = 1'b0;

        // ---- Reset state
        tick();
        tick();
        check("rst_status", status_o, 32'h10000000);
        check("rst_count", count_o, 32'd0);
        check("rst_cause", cause_o, 32'd0);
        check("rst_int_req", {31'd0, int_req_o}, 32'd0);
        check("rst_rdata_status", rdata_o, 32'd0);
        raddr_i = 5'd15; #1;
        check("rst_rdata_prid", rdata_o, 32'd0);

        rst = 1'b0; #1;
        check("rdata_prid", rdata_o, 32'h00004220);

        // ---- Prescaled Count: 10 cycles at CNT_DIV=2 gives 5
        repeat (10) tick();
        check("count_after_10", count_o, 32'd5);
        check("timer_idle_cmp0", {31'd0, timer_int_o}, 32'd0);
        raddr_i = 5'd9; #1;
        check("rdata_count", rdata_o, 32'd5);
        raddr_i = 5'd3; #1;
        check("rdata_unmapped", rdata_o, 32'd0);

        // ---- Count load, no bypass, wrap
        raddr_i = 5'd9;
        we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hFFFFFFFF; #1;
        check("rdata_no_bypass", rdata_o, 32'd5);
        tick();
        we_i = 1'b0;
        check("count_loaded", count_o, 32'hFFFFFFFF);
        tick();
        check("count_held", count_o, 32'hFFFFFFFF);
        tick();
        check("count_wrap", count_o, 32'd0);

        // ---- Timer interrupt
        sw_write(5'd11, 32'd20);
        sw_write(5'd12, 32'h00008001);
        check("status_written", status_o, 32'h10008001);
        check("compare_written", compare_o, 32'd20);
        wait_count(32'd20, "wait_count_20");
        check("timer_not_yet", {31'd0, timer_int_o}, 32'd0);
        tick();
        check("timer_set", {31'd0, timer_int_o}, 32'd1);
        check("cause_ip7_timer", cause_o, 32'h00008000);
        check("int_req_timer", {31'd0, int_req_o}, 32'd1);
        repeat (4) tick();
        check("timer_sticky", {31'd0, timer_int_o}, 32'd1);
        sw_write(5'd11, 32'd0);
        check("timer_cleared", {31'd0, timer_int_o}, 32'd0);
        check("int_req_cleared", {31'd0, int_req_o}, 32'd0);

        // ---- Compare write beats a same-cycle match
        target = count_o + 32'd3;
        sw_write(5'd11, target);
        wait_count(target, "wait_count_target");
        sw_write(5'd11, target);
        check("cmp_write_wins", {31'd0, timer_int_o}, 32'd0);
        sw_write(5'd11, 32'd0);

        // ---- Software interrupt bits and read-zero masking in Cause
        sw_write(5'd13, 32'hFFFFFFFF);
        check("cause_sw_mask", cause_o, 32'h00000300);
        check("int_req_masked", {31'd0, int_req_o}, 32'd0);
        sw_write(5'd12, 32'h00000101);
        check("int_req_sw", {31'd0, int_req_o}, 32'd1);
        sw_write(5'd13, 32'd0);
        check("int_req_sw_off", {31'd0, int_req_o}, 32'd0);

        // ---- Hardware line 2 -> Cause[12]
        int_i = 6'b000100;
        sw_write(5'd12, 32'h00001001);
        check("cause_hw_ip4", cause_o, 32'h00001000);
        check("int_req_hw", {31'd0, int_req_o}, 32'd1);

        // ---- Exception in a delay slot, AdEL
        set_exc(32'hBFC00100, 1'b1, 5'd4, 32'h3);
        tick();
        exc_valid_i = 1'b0;
        check("exc1_epc", epc_o, 32'hBFC000FC);
        check("exc1_cause", cause_o, 32'h80001010);
        check("exc1_badvaddr", badvaddr_o, 32'h3);
        check("exc1_status", status_o, 32'h10001003);
        check("exc1_int_req", {31'd0, int_req_o}, 32'd0);

        // ---- Nested exception, AdES
        set_exc(32'h80000000, 1'b0, 5'd5, 32'h44);
        tick();
        exc_valid_i = 1'b0;
        check("exc2_epc_kept", epc_o, 32'hBFC000FC);
        check("exc2_cause", cause_o, 32'h80001014);
        check("exc2_badvaddr", badvaddr_o, 32'h44);
        pulse_eret();
        check("eret_status", status_o, 32'h10001001);
        check("eret_int_req", {31'd0, int_req_o}, 32'd1);

        // ---- Non-address exception leaves BadVAddr
        set_exc(32'h80000020, 1'b0, 5'd8, 32'h99);
        tick();
        exc_valid_i = 1'b0;
        check("exc3_epc", epc_o, 32'h80000020);
        check("exc3_cause", cause_o, 32'h00001020);
        check("exc3_badvaddr", badvaddr_o, 32'h44);
        pulse_eret();

        // ---- Exception beats a same-cycle EPC write
        set_exc(32'h80000100, 1'b0, 5'd10, 32'h0);
        sw_write(5'd14, 32'h00001234);
        exc_valid_i = 1'b0;
        check("exc_vs_epc_write", epc_o, 32'h80000100);
        raddr_i = 5'd14; #1;
        check("rdata_epc", rdata_o, 32'h80000100);
        pulse_eret();

        // ---- Exception beats EXL of a same-cycle Status write; IM/IE still land
        set_exc(32'h80000200, 1'b0, 5'd12, 32'h0);
        sw_write(5'd12, 32'h00000000);
        exc_valid_i = 1'b0;
        check("exc_vs_status_write", status_o, 32'h10000002);

        // ---- eret beats EXL of a same-cycle Status write
        eret_i = 1'b1;
        sw_write(5'd12, 32'h00000003);
        eret_i = 1'b0;
        check("eret_vs_status_write", status_o, 32'h10000001);

        sw_write(5'd14, 32'h00001234);
        check("epc_sw_write", epc_o, 32'h00001234);

        // ---- Exception beats a same-cycle eret
        set_exc(32'h00000300, 1'b0, 5'd0, 32'h0);
        pulse_eret();
        exc_valid_i = 1'b0;
        check("exc_vs_eret", status_o, 32'h10000003);
        check("exc_vs_eret_epc", epc_o, 32'h00000300);

        // ---- Reset overrides a coincident exception and write
        rst = 1'b1;
        set_exc(32'h00000400, 1'b0, 5'd4, 32'h55);
        raddr_i = 5'd12;
        sw_write(5'd12, 32'hFFFFFFFF);
        exc_valid_i = 1'b0;
        check("rst2_status", status_o, 32'h10000000);
        check("rst2_epc", epc_o, 32'd0);
        check("rst2_badvaddr", badvaddr_o, 32'd0);
        check("rst2_cause", cause_o, 32'd0);
        check("rst2_count", count_o, 32'd0);
        check("rst2_rdata", rdata_o, 32'd0);
        check("rst2_int_req", {31'd0, int_req_o}, 32'd0);
        rst = 1'b0;
        int_i = '0;
        tick();
        check("post_rst_count", count_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
